sdram_ctrl_emu: RTL and testbench

Cycle-approximate responder for the SDRAM controller user-side interface, backed by on-chip block RAM instead of external SDRAM. It is a drop-in replacement for the controller under the existing burst-test harness and camera frame-buffer logic, for simulation and board bring-up without the SDRAM device. It accepts one-cycle burst commands, consumes write bursts through the write strobe and returns read bursts with data-valid. Init delay and CAS-like latencies are modelled.

---
 rtl/sdram_emu_pkg.sv | 27 ++
 rtl/sdram_emu_mem.sv | 23 ++
 rtl/sdram_ctrl_emu.sv | 141 ++++++++++++++
 tb/tb_sdram_ctrl_emu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_emu_pkg.sv
// Shared definitions for the block-RAM backed SDRAM controller emulator:
// FSM state encoding, default latencies and a constant log2 helper.
package sdram_emu_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_READ    = 3'd5
    } state_t;

    localparam int DEFAULT_WR_LAT = 2;
    localparam int DEFAULT_RD_LAT = 3;

    // Smallest r with 2**r >= value; usable in parameter expressions.
    function automatic int clog2_int(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_emu_mem.sv
// Single-port synchronous RAM standing in for the SDRAM array.
// Read-first, registered read data, no reset so it maps onto block RAM.
module sdram_emu_mem #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << MEM_AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sdram_ctrl_emu.sv
// Cycle-approximate SDRAM controller user-side responder backed by block RAM.
// Models init delay, write-strobe and CAS-like read latency for full-page bursts.
module sdram_ctrl_emu
    import sdram_emu_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int BURST_LEN   = 512,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 200,
    parameter int WR_LAT      = DEFAULT_WR_LAT,
    parameter int RD_LAT      = DEFAULT_RD_LAT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_sdram_en,
    input  logic              i_rw,
    input  logic [DATA_W-1:0] i_datain,
    output logic [DATA_W-1:0] o_dataout,
    output logic              o_dataval,
    output logic              is_writing,
    output logic              o_ready
);

    localparam int IDX_W   = clog2_int(BURST_LEN) + 1;
    localparam int INIT_W  = clog2_int(INIT_CYCLES + 1);
    localparam int LAT_MAX = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int WAIT_W  = clog2_int(LAT_MAX + 1);

    state_t              state;
    state_t              state_nxt;
    logic [INIT_W-1:0]   init_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]    idx;
    logic [MEM_AW-1:0]   base;
    logic [MEM_AW-1:0]   mem_addr;
    logic                mem_we;
    logic                ready_nxt;
    logic                writing_nxt;
    logic                vld_p0;
    logic                vld_p1;
    logic [DATA_W-1:0]   rd_data_p1;

    if (ADDR_W > MEM_AW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^i_addr[ADDR_W-1:MEM_AW];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // READ spans BURST_LEN issue cycles plus the two-cycle RAM/output pipeline,
    // so the controller reports ready only after the last word has been shown.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT:    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_nxt = ST_IDLE;
            ST_IDLE:    if (i_sdram_en) state_nxt = i_rw ? ST_RD_WAIT : ST_WR_WAIT;
            ST_WR_WAIT: if (wait_cnt == WAIT_W'(WR_LAT - 1)) state_nxt = ST_WRITE;
            ST_WRITE:   if (idx == IDX_W'(BURST_LEN - 1)) state_nxt = ST_IDLE;
            ST_RD_WAIT: if (wait_cnt == WAIT_W'(RD_LAT - 3)) state_nxt = ST_READ;
            ST_READ:    if (idx == IDX_W'(BURST_LEN + 1)) state_nxt = ST_IDLE;
            default:    state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        ready_nxt   = (state_nxt == ST_IDLE);
        writing_nxt = (state_nxt == ST_WRITE);
        vld_p0      = (state == ST_READ) && (idx < IDX_W'(BURST_LEN));
        mem_we      = (state == ST_WRITE);
        mem_addr    = base + MEM_AW'(idx);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            init_cnt <= '0;
            wait_cnt <= '0;
            idx      <= '0;
            base     <= '0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (state == ST_WR_WAIT || state == ST_RD_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == ST_IDLE) begin
                idx <= '0;
                if (i_sdram_en) begin
                    base <= i_addr[MEM_AW-1:0];
                end
            end else if (state == ST_WRITE || state == ST_READ) begin
                idx <= idx + 1'b1;
            end
        end
    end

    sdram_emu_mem #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk   (i_clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (i_datain),
        .rdata (rd_data_p1)
    );

    // p0 -> p1: address issued, RAM registers the word; p1 -> out: output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready    <= 1'b0;
            is_writing <= 1'b0;
            vld_p1     <= 1'b0;
            o_dataval  <= 1'b0;
        end else begin
            o_ready    <= ready_nxt;
            is_writing <= writing_nxt;
            vld_p1     <= vld_p0;
            o_dataval  <= vld_p1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dataout <= '0;
        end else if (vld_p1) begin
            o_dataout <= rd_data_p1;
        end
    end

endmodule

// File: tb/tb_sdram_ctrl_emu.sv
// Scoreboard bench for sdram_ctrl_emu: randomized bursts against a flat-array
// memory model; a monitor pops expected read words whenever o_dataval is high.
module tb_sdram_ctrl_emu;

    localparam int BL    = 512;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic [14:0] i_addr;
    logic        i_sdram_en;
    logic        i_rw;
    logic [15:0] i_datain;
    logic [15:0] o_dataout;
    logic        o_dataval;
    logic        is_writing;
    logic        o_ready;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] mem_model [DEPTH];
    logic [15:0] exp_q [$];

    sdram_ctrl_emu dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_addr     (i_addr),
        .i_sdram_en (i_sdram_en),
        .i_rw       (i_rw),
        .i_datain   (i_datain),
        .o_dataout  (o_dataout),
        .o_dataval  (o_dataval),
        .is_writing (is_writing),
        .o_ready    (o_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every presented read word must match the head of the queue.
    initial begin
        logic [15:0] w;
        forever begin
            @(negedge clk);
            if (!rst && o_dataval) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dataval", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("read_data", o_dataout, w);
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (o_ready !== 1'b1) check("ready_timeout", 0, 1);
    endtask

    task automatic init_phase(input bit poke);
        int n;
        int seen;
        n = 0;
        seen = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        while (o_ready !== 1'b1 && n < 1000) begin
            i_sdram_en = poke && (n == 50 || n == 120);
            i_rw = (n == 50);
            @(posedge clk);
            #1;
            n++;
            if (is_writing || o_dataval) seen++;
        end
        i_sdram_en = 1'b0;
        check("init_cycles", n, 200);
        check("init_no_activity", seen, 0);
    endtask

    task automatic do_write(input logic [14:0] addr, input int kind, input bit spam, input int abort_at);
        int k;
        int acc;
        int first;
        int n;
        bit done;
        logic [15:0] w;
        @(negedge clk);
        wait_ready();
        i_addr = addr;
        i_rw = 1'b0;
        i_sdram_en = 1'b1;
        acc = cyc + 1;
        k = 0;
        first = -1;
        n = 0;
        done = 1'b0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if (is_writing) begin
                if (first < 0) first = cyc;
                if (k == abort_at) begin
                    i_sdram_en = 1'b0;
                    #2 rst = 1'b1;
                    #1;
                    check("rst_is_writing", is_writing, 0);
                    check("rst_ready", o_ready, 0);
                    check("rst_dataval", o_dataval, 0);
                    return;
                end
                w = (kind == 0) ? 16'(777 + k) : 16'($urandom);
                i_datain = w;
                mem_model[10'(int'(addr[9:0]) + k)] = w;
                k++;
                i_sdram_en = spam;
            end else if (k > 0) begin
                done = 1'b1;
                i_sdram_en = 1'b0;
                check("wr_ready_after_burst", o_ready, 1);
            end else begin
                i_sdram_en = spam;
            end
        end
        check("wr_start_latency", first - acc, 2);
        check("wr_length", k, BL);
    endtask

    task automatic do_read(input logic [14:0] addr);
        int acc;
        int first;
        int cnt;
        int n;
        bit done;
        @(negedge clk);
        wait_ready();
        for (int k = 0; k < BL; k++) exp_q.push_back(mem_model[10'(int'(addr[9:0]) + k)]);
        i_addr = addr;
        i_rw = 1'b1;
        i_sdram_en = 1'b1;
        acc = cyc + 1;
        first = -1;
        cnt = 0;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            i_sdram_en = 1'b0;
            if (o_dataval) begin
                if (first < 0) first = cyc;
                cnt++;
            end else if (cnt > 0) begin
                done = 1'b1;
            end
        end
        check("rd_first_latency", first - acc, 3);
        check("rd_length", cnt, BL);
        check("rd_count_mod256", cnt % 256, 0);
        check("rd_queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [14:0] a;
        int seen;
        rst = 1'b1;
        i_addr = '0;
        i_sdram_en = 1'b0;
        i_rw = 1'b0;
        i_datain = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", o_ready, 0);
        check("reset_dataval", o_dataval, 0);
        check("reset_is_writing", is_writing, 0);
        check("reset_dataout", o_dataout, 0);

        init_phase(1'b1);

        do_write(15'd0, 0, 1'b0, -1);
        do_read(15'd0);

        a = {5'($urandom), 10'd1000};
        do_write(a, 1, 1'b0, -1);
        do_read({5'($urandom), 10'd1000});
        do_read(15'd0);

        do_write({5'($urandom), 10'd512}, 1, 1'b1, -1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (is_writing) seen++;
        end
        check("spam_no_extra_burst", seen, 0);
        check("spam_ready_held", o_ready, 1);
        do_read(15'd512);

        for (int i = 0; i < 2; i++) begin
            do_write(15'($urandom), 1, 1'b0, -1);
            do_read(15'($urandom));
        end

        a = 15'($urandom);
        do_write(a, 1, 1'b0, 100);
        repeat (2) @(negedge clk);
        init_phase(1'b0);
        do_read(a);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
